// File: rtl/xor_sweep_ctrl_if.sv
// Signal bundle between the XOR-cell sweep controller (slave) and its host/cell bank (master).
// start is a level sampled only while the controller is idle. There is no ready signal: busy high means start is ignored.
interface xor_sweep_ctrl_if #(
    parameter int N_CELLS = 2,
    parameter int ERR_W   = 8
);
    logic               start;
    logic               mask_we;
    logic [N_CELLS-1:0] mask_in;
    logic               cell_a;
    logic               cell_b;
    logic [N_CELLS-1:0] cell_v;
    logic [N_CELLS-1:0] cell_z;
    logic               busy;
    logic               done;
    logic [2:0]         phase;
    logic [ERR_W-1:0]   err_count;
    logic [N_CELLS-1:0] err_map;
    logic [1:0]         dbg_state;

    modport slave (
        input  start, mask_we, mask_in, cell_z,
        output cell_a, cell_b, cell_v, busy, done, phase, err_count, err_map, dbg_state
    );

    modport master (
        output start, mask_we, mask_in, cell_z,
        input  cell_a, cell_b, cell_v, busy, done, phase, err_count, err_map, dbg_state
    );
endinterface

// File: rtl/xor_sweep_ctrl.sv
// Sweeps all a/b operand pairs over a bank of XOR cells under the programmed and inverted mask.
// Every cell output is checked against a^b^v, giving a saturating error count and a sticky error map.
module xor_sweep_ctrl #(
    parameter int N_CELLS = 2,
    parameter int SETTLE  = 1,
    parameter int ERR_W   = 8
) (
    input  logic              clk,
    input  logic              reset,
    xor_sweep_ctrl_if.slave   bus
);
    localparam int SW = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_q;
    logic [N_CELLS-1:0] mask_q;
    logic [N_CELLS-1:0] cell_v_q;
    logic               cell_a_q;
    logic               cell_b_q;
    logic               busy_q;
    logic               done_q;
    logic [2:0]         k_q;
    logic [2:0]         k_d;
    logic [SW-1:0]      cnt_q;
    logic [ERR_W-1:0]   err_count_q;
    logic [ERR_W-1:0]   err_count_d;
    logic [N_CELLS-1:0] err_map_q;
    logic [N_CELLS-1:0] err_map_d;
    logic [N_CELLS-1:0] diff;

    // Expected value comes from the registered drive, which the cells have had SETTLE+1 cycles to see.
    always_comb begin
        diff        = bus.cell_z ^ (cell_v_q ^ {N_CELLS{cell_a_q ^ cell_b_q}});
        err_map_d   = err_map_q | diff;
        err_count_d = err_count_q;
        for (int i = 0; i < N_CELLS; i++) begin
            if (diff[i] && (err_count_d != {ERR_W{1'b1}})) begin
                err_count_d = err_count_d + ERR_W'(1);
            end
        end
        k_d = k_q + 3'd1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            mask_q      <= '0;
            cell_v_q    <= '0;
            cell_a_q    <= 1'b0;
            cell_b_q    <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            k_q         <= 3'd0;
            cnt_q       <= '0;
            err_count_q <= '0;
            err_map_q   <= '0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    cell_a_q <= 1'b0;
                    cell_b_q <= 1'b0;
                    k_q      <= 3'd0;
                    // A write coinciding with start is visible on the very first vector.
                    if (bus.mask_we) begin
                        mask_q   <= bus.mask_in;
                        cell_v_q <= bus.mask_in;
                    end else begin
                        cell_v_q <= mask_q;
                    end
                    if (bus.start) begin
                        state_q     <= RUN;
                        busy_q      <= 1'b1;
                        cnt_q       <= SW'(SETTLE);
                        err_count_q <= '0;
                        err_map_q   <= '0;
                    end
                end
                RUN: begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - SW'(1);
                    end else begin
                        err_count_q <= err_count_d;
                        err_map_q   <= err_map_d;
                        if (k_q == 3'd7) begin
                            state_q  <= DONE;
                            busy_q   <= 1'b0;
                            done_q   <= 1'b1;
                            cell_a_q <= 1'b0;
                            cell_b_q <= 1'b0;
                            cell_v_q <= mask_q;
                            k_q      <= 3'd0;
                        end else begin
                            k_q      <= k_d;
                            cell_a_q <= k_d[0];
                            cell_b_q <= k_d[1];
                            cell_v_q <= mask_q ^ {N_CELLS{k_d[2]}};
                            cnt_q    <= SW'(SETTLE);
                        end
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.cell_a    = cell_a_q;
    assign bus.cell_b    = cell_b_q;
    assign bus.cell_v    = cell_v_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.phase     = k_q;
    assign bus.err_count = err_count_q;
    assign bus.err_map   = err_map_q;
    assign bus.dbg_state = state_q;
endmodule

// File: tb/tb_xor_sweep_ctrl.sv
// Bench for xor_sweep_ctrl: two instances (SETTLE=1/ERR_W=8 and SETTLE=0/ERR_W=2) driving modelled XOR cells.
// Expected sweep results come from a per-vector truth-table model of the cells and the mask rules.
module tb_xor_sweep_ctrl;
    logic clk = 1'b0;
    logic reset;
    int   n_tests = 0;
    int   n_fail  = 0;

    // Cell fault modes: 0 ideal, 1 stuck at 0, 2 stuck at 1, 3 inverted output.
    int fault1 [2];
    int fault2 [2];

    xor_sweep_ctrl_if #(.N_CELLS(2), .ERR_W(8)) bus1 ();
    xor_sweep_ctrl_if #(.N_CELLS(2), .ERR_W(2)) bus2 ();

    xor_sweep_ctrl #(.N_CELLS(2), .SETTLE(1), .ERR_W(8)) u_dut (
        .clk(clk), .reset(reset), .bus(bus1)
    );
    xor_sweep_ctrl #(.N_CELLS(2), .SETTLE(0), .ERR_W(2)) u_dut2 (
        .clk(clk), .reset(reset), .bus(bus2)
    );

    always #5 clk = ~clk;

    function automatic logic cell_out(input logic a, input logic b, input logic v, input int mode);
        case (mode)
            1:       return 1'b0;
            2:       return 1'b1;
            3:       return ~(a ^ b ^ v);
            default: return a ^ b ^ v;
        endcase
    endfunction

    always_comb begin
        bus1.cell_z = '0;
        bus2.cell_z = '0;
        for (int i = 0; i < 2; i++) begin
            bus1.cell_z[i] = cell_out(bus1.cell_a, bus1.cell_b, bus1.cell_v[i], fault1[i]);
            bus2.cell_z[i] = cell_out(bus2.cell_a, bus2.cell_b, bus2.cell_v[i], fault2[i]);
        end
    end

    // Walk the eight vectors, count every cell whose output differs from a^b^v, saturate at max_cnt.
    function automatic void ref_sweep(input logic [1:0] mask, input int f0, input int f1,
                                      input int max_cnt, output int cnt, output logic [1:0] map);
        int   total;
        logic a, b, v, e, z;
        total = 0;
        map   = 2'b00;
        for (int k = 0; k < 8; k++) begin
            a = (k % 2) == 1;
            b = ((k / 2) % 2) == 1;
            for (int i = 0; i < 2; i++) begin
                v = mask[i] ^ (k >= 4);
                e = a ^ b ^ v;
                z = cell_out(a, b, v, (i == 0) ? f0 : f1);
                if (z != e) begin
                    total++;
                    map[i] = 1'b1;
                end
            end
        end
        cnt = (total > max_cnt) ? max_cnt : total;
    endfunction

    task automatic program_mask1(input logic [1:0] m);
        @(negedge clk);
        bus1.mask_we = 1'b1;
        bus1.mask_in = m;
        @(negedge clk);
        bus1.mask_we = 1'b0;
        n_tests++;
        if (bus1.cell_v !== m) begin
            n_fail++;
            $display("FAIL mask_prog: cell_v got %b expected %b", bus1.cell_v, m);
        end
    endtask

    // Full cycle-by-cycle sweep on instance 1; disturb pokes start/mask_we mid-sweep and in the DONE cycle.
    task automatic sweep1(input logic [1:0] m, input bit with_start_we, input bit disturb, input string tag);
        int          exp_cnt;
        logic [1:0]  exp_map;
        logic [2:0]  kk;
        logic [8:0]  got, want;
        ref_sweep(m, fault1[0], fault1[1], 255, exp_cnt, exp_map);
        @(negedge clk);
        bus1.start = 1'b1;
        if (with_start_we) begin
            bus1.mask_we = 1'b1;
            bus1.mask_in = m;
        end
        @(negedge clk);
        bus1.start   = 1'b0;
        bus1.mask_we = 1'b0;
        for (int e = 0; e < 16; e++) begin
            kk   = 3'(e / 2);
            got  = {bus1.busy, bus1.done, bus1.phase, bus1.cell_a, bus1.cell_b, bus1.cell_v};
            want = {1'b1, 1'b0, kk, kk[0], kk[1], m ^ {2{kk[2]}}};
            n_tests++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL %s_vec_edge%0d: busy,done,phase,a,b,v got %b expected %b", tag, e, got, want);
            end
            if (disturb) begin
                if (e == 6) bus1.start = 1'b1;
                if (e == 7) bus1.start = 1'b0;
                if (e == 10) begin
                    bus1.mask_we = 1'b1;
                    bus1.mask_in = ~m;
                end
                if (e == 11) bus1.mask_we = 1'b0;
            end
            @(negedge clk);
        end
        got  = {bus1.busy, bus1.done, bus1.phase, bus1.cell_a, bus1.cell_b, bus1.cell_v};
        want = {1'b0, 1'b1, 3'd0, 1'b0, 1'b0, m};
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s_done_edge16: busy,done,phase,a,b,v got %b expected %b", tag, got, want);
        end
        n_tests++;
        if (bus1.err_count !== 8'(exp_cnt) || bus1.err_map !== exp_map) begin
            n_fail++;
            $display("FAIL %s_result: err_count %0d err_map %b expected %0d %b",
                     tag, bus1.err_count, bus1.err_map, exp_cnt, exp_map);
        end
        if (disturb) bus1.start = 1'b1;
        @(negedge clk);
        bus1.start = 1'b0;
        got  = {bus1.busy, bus1.done, bus1.phase, bus1.cell_a, bus1.cell_b, bus1.cell_v};
        want = {1'b0, 1'b0, 3'd0, 1'b0, 1'b0, m};
        n_tests++;
        if (got !== want || bus1.err_count !== 8'(exp_cnt) || bus1.err_map !== exp_map) begin
            n_fail++;
            $display("FAIL %s_idle_after: outputs %b cnt %0d map %b expected %b cnt %0d map %b",
                     tag, got, bus1.err_count, bus1.err_map, want, exp_cnt, exp_map);
        end
        // A start in the DONE cycle must not launch a sweep.
        @(negedge clk);
        n_tests++;
        if (bus1.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_no_restart: busy got %b expected 0", tag, bus1.busy);
        end
    endtask

    task automatic sweep2(input logic [1:0] m, input string tag);
        int         exp_cnt;
        logic [1:0] exp_map;
        int         n;
        ref_sweep(m, fault2[0], fault2[1], 3, exp_cnt, exp_map);
        @(negedge clk);
        bus2.start   = 1'b1;
        bus2.mask_we = 1'b1;
        bus2.mask_in = m;
        @(negedge clk);
        bus2.start   = 1'b0;
        bus2.mask_we = 1'b0;
        n = 0;
        while (bus2.done !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        n_tests++;
        if (n != 8) begin
            n_fail++;
            $display("FAIL %s_done_edge: done seen at edge %0d expected 8", tag, n);
        end
        n_tests++;
        if (bus2.err_count !== 2'(exp_cnt) || bus2.err_map !== exp_map || bus2.cell_v !== m) begin
            n_fail++;
            $display("FAIL %s_result: err_count %0d err_map %b cell_v %b expected %0d %b %b",
                     tag, bus2.err_count, bus2.err_map, bus2.cell_v, exp_cnt, exp_map, m);
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        n_tests++;
        if ({bus1.busy, bus1.done, bus1.phase, bus1.cell_a, bus1.cell_b, bus1.cell_v,
             bus1.err_count, bus1.err_map} !== '0) begin
            n_fail++;
            $display("FAIL reset_dut1: outputs not all zero (v %b cnt %0d)", bus1.cell_v, bus1.err_count);
        end
        n_tests++;
        if ({bus2.busy, bus2.done, bus2.phase, bus2.cell_a, bus2.cell_b, bus2.cell_v,
             bus2.err_count, bus2.err_map} !== '0) begin
            n_fail++;
            $display("FAIL reset_dut2: outputs not all zero (v %b cnt %0d)", bus2.cell_v, bus2.err_count);
        end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_ideal();
        fault1[0] = 0;
        fault1[1] = 0;
        program_mask1(2'b00);
        sweep1(2'b00, 1'b0, 1'b0, "ideal_m00");
        program_mask1(2'b01);
        sweep1(2'b01, 1'b0, 1'b0, "ideal_m01");
    endtask

    task automatic test_stuck();
        fault1[0] = 0;
        fault1[1] = 1;
        program_mask1(2'b00);
        sweep1(2'b00, 1'b0, 1'b0, "stuck_first");
        sweep1(2'b00, 1'b0, 1'b0, "stuck_again");
    endtask

    task automatic test_ignore_inputs();
        fault1[0] = 0;
        fault1[1] = 0;
        program_mask1(2'b00);
        sweep1(2'b00, 1'b0, 1'b1, "ignore");
    endtask

    task automatic test_reset_midsweep();
        logic [8:0] got;
        fault1[0] = 0;
        fault1[1] = 0;
        program_mask1(2'b10);
        @(negedge clk);
        bus1.start = 1'b1;
        @(negedge clk);
        bus1.start = 1'b0;
        repeat (10) @(negedge clk);
        n_tests++;
        if (bus1.phase !== 3'd5) begin
            n_fail++;
            $display("FAIL midsweep_phase: phase got %0d expected 5", bus1.phase);
        end
        reset = 1'b1;
        #1;
        got = {bus1.busy, bus1.done, bus1.phase, bus1.cell_a, bus1.cell_b, bus1.cell_v};
        n_tests++;
        if (got !== '0 || bus1.err_count !== '0 || bus1.err_map !== '0) begin
            n_fail++;
            $display("FAIL midsweep_reset: outputs %b cnt %0d got, expected all zero", got, bus1.err_count);
        end
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus1.done !== 1'b0 || bus1.busy !== 1'b0) begin
                n_tests++;
                n_fail++;
                $display("FAIL midsweep_no_done: done %b busy %b at cycle %0d expected 0 0", bus1.done, bus1.busy, i);
            end
        end
        n_tests++;
        if (bus1.cell_v !== 2'b00) begin
            n_fail++;
            $display("FAIL midsweep_mask_cleared: cell_v got %b expected 00", bus1.cell_v);
        end
        sweep1(2'b00, 1'b0, 1'b0, "after_reset");
    endtask

    task automatic test_random();
        logic [1:0] m;
        bit         swe;
        for (int it = 0; it < 10; it++) begin
            m         = 2'($urandom_range(0, 3));
            fault1[0] = int'($urandom_range(0, 3));
            fault1[1] = int'($urandom_range(0, 3));
            swe       = 1'($urandom_range(0, 1));
            if (!swe) program_mask1(m);
            sweep1(m, swe, 1'b0, $sformatf("rand%0d", it));
        end
    endtask

    task automatic test_saturation_settle0();
        fault2[0] = 3;
        fault2[1] = 3;
        sweep2(2'b00, "sat_inv");
        sweep2(2'b11, "sat_inv_m11");
        for (int it = 0; it < 6; it++) begin
            fault2[0] = int'($urandom_range(0, 3));
            fault2[1] = int'($urandom_range(0, 3));
            sweep2(2'($urandom_range(0, 3)), $sformatf("s0rand%0d", it));
        end
    endtask

    initial begin
        reset        = 1'b1;
        fault1[0]    = 0;
        fault1[1]    = 0;
        fault2[0]    = 0;
        fault2[1]    = 0;
        bus1.start   = 1'b0;
        bus1.mask_we = 1'b0;
        bus1.mask_in = '0;
        bus2.start   = 1'b0;
        bus2.mask_we = 1'b0;
        bus2.mask_in = '0;
        test_reset();
        test_ideal();
        test_stuck();
        test_ignore_inputs();
        test_reset_midsweep();
        test_random();
        test_saturation_settle0();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end
endmodule
